lsu_ram_port: RTL and testbench

LSU_RAM_PORT -- requirements
Module: lsu_ram_port

---
 rtl/lsu_ram_port.sv | 192 +++++++++++++++++++
 tb/tb_lsu_ram_port.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_port.sv
// Load/store port between the pipeline and a byte-addressed single-port RAM.
// One request is in flight at a time. Each accepted request is checked for
// legality, range and alignment. Legal requests issue a one-cycle RAM strobe.
// Faulted requests go straight to the response and never touch the RAM.
module lsu_ram_port #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic [15:0] fault_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  localparam logic [1:0] CauseNone      = 2'b00;
  localparam logic [1:0] CauseMisalign  = 2'b01;
  localparam logic [1:0] CauseRange     = 2'b10;
  localparam logic [1:0] CauseIllegal   = 2'b11;

  // One extra bit so a MEM_SIZE near 2^32 still compares correctly.
  localparam logic [32:0] MemLimit = 33'(MEM_SIZE);

  state_e      state_q;
  logic        req_ready_q;
  logic        kind_load_q;
  logic        mem_load_q;
  logic        mem_store_q;
  logic [2:0]  mem_access_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        resp_fault_q;
  logic [1:0]  resp_cause_q;
  logic [15:0] fault_count_q;

  logic        legal_acc;
  logic        illegal;
  logic        out_of_range;
  logic        misaligned;
  logic [1:0]  cause_d;
  logic [15:0] fault_count_d;

  // Classify the incoming request; illegal beats range beats alignment.
  always_comb begin
    legal_acc    = 1'b0;
    misaligned   = 1'b0;
    case (req_access)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_acc = 1'b1;
      default:                                legal_acc = 1'b0;
    endcase
    case (req_access[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    illegal      = (req_load == req_store) || !legal_acc ||
                   (req_store && req_access[2]);
    out_of_range = ({1'b0, req_addr} >= MemLimit);
    if (illegal) begin
      cause_d = CauseIllegal;
    end else if (out_of_range) begin
      cause_d = CauseRange;
    end else if (misaligned) begin
      cause_d = CauseMisalign;
    end else begin
      cause_d = CauseNone;
    end
  end

  // Saturating increment of the fault counter.
  always_comb begin
    fault_count_d = fault_count_q;
    if (fault_count_q != '1) begin
      fault_count_d = fault_count_q + 16'd1;
    end
  end

  // Request FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      kind_load_q   <= 1'b0;
      mem_load_q    <= 1'b0;
      mem_store_q   <= 1'b0;
      mem_access_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_rd_q     <= '0;
      resp_fault_q  <= 1'b0;
      resp_cause_q  <= '0;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req_ready_q) begin
            // First edge out of reset only opens the port.
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            req_ready_q  <= 1'b0;
            kind_load_q  <= req_load;
            mem_access_q <= req_access;
            mem_addr_q   <= req_addr;
            mem_wdata_q  <= req_wdata;
            resp_rd_q    <= req_rd;
            resp_rdata_q <= '0;
            resp_cause_q <= cause_d;
            if (cause_d != CauseNone) begin
              resp_fault_q  <= 1'b1;
              resp_valid_q  <= 1'b1;
              fault_count_q <= fault_count_d;
              state_q       <= RESP;
            end else begin
              resp_fault_q <= 1'b0;
              mem_load_q   <= req_load;
              mem_store_q  <= req_store;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_load_q  <= 1'b0;
          mem_store_q <= 1'b0;
          if (kind_load_q) begin
            state_q <= CAPTURE;
          end else begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        CAPTURE: begin
          resp_rdata_q <= mem_rdata;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_load    = mem_load_q;
  assign mem_store   = mem_store_q;
  assign mem_access  = mem_access_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_rd     = resp_rd_q;
  assign resp_fault  = resp_fault_q;
  assign resp_cause  = resp_cause_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_lsu_ram_port.sv
// Bench for lsu_ram_port: a byte RAM environment, an independent reference
// memory and fault counter, directed cases followed by random requests.
module tb_lsu_ram_port;

  localparam int unsigned MEM_SIZE = 4096;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_access;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_load;
  logic        mem_store;
  logic [2:0]  mem_access;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic [15:0] fault_count;

  int checks;
  int errors;
  int exp_faults;
  logic ram_clear;

  logic [7:0] ram     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  lsu_ram_port #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_access (req_access),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .mem_access (mem_access),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_fault (resp_fault),
    .resp_cause (resp_cause),
    .fault_count(fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign/zero extension as the RAM performs it, little-endian bytes.
  function automatic logic [31:0] extend(input logic [2:0] acc, input logic [7:0] b0,
                                         input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3);
    case (acc)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [7:0] ram_b(input int unsigned a);
    return (a < MEM_SIZE) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_b(input int unsigned a);
    return (a < MEM_SIZE) ? ref_mem[a] : 8'h00;
  endfunction

  // RAM environment: registered read, byte/half/word write, garbage when idle.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < int'(MEM_SIZE); i++) ram[i] <= 8'h00;
    end else if (mem_store) begin
      ram[mem_addr % MEM_SIZE] <= mem_wdata[7:0];
      if (mem_access[1:0] != 2'b00) ram[(mem_addr + 1) % MEM_SIZE] <= mem_wdata[15:8];
      if (mem_access[1:0] == 2'b10) begin
        ram[(mem_addr + 2) % MEM_SIZE] <= mem_wdata[23:16];
        ram[(mem_addr + 3) % MEM_SIZE] <= mem_wdata[31:24];
      end
    end
    if (mem_load) begin
      mem_rdata <= extend(mem_access, ram_b(mem_addr), ram_b(mem_addr + 1),
                          ram_b(mem_addr + 2), ram_b(mem_addr + 3));
    end else begin
      mem_rdata <= $urandom;
    end
  end

  function automatic logic [1:0] exp_cause(input logic ld, input logic st,
                                           input logic [2:0] acc, input logic [31:0] addr);
    bit legal;
    legal = (acc == 3'd0) || (acc == 3'd1) || (acc == 3'd2) || (acc == 3'd4) || (acc == 3'd5);
    if ((ld == st) || !legal || (st && (acc == 3'd4 || acc == 3'd5))) return 2'b11;
    if (addr >= MEM_SIZE) return 2'b10;
    if ((acc == 3'd1 || acc == 3'd5) && (addr % 2 != 0)) return 2'b01;
    if ((acc == 3'd2) && (addr % 4 != 0)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] acc, input logic [31:0] addr);
    return extend(acc, ref_b(addr), ref_b(addr + 1), ref_b(addr + 2), ref_b(addr + 3));
  endfunction

  function automatic void ref_write(input logic [2:0] acc, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    ref_mem[addr] = wdata[7:0];
    if (acc[1:0] != 2'b00) ref_mem[addr + 1] = wdata[15:8];
    if (acc[1:0] == 2'b10) begin
      ref_mem[addr + 2] = wdata[23:16];
      ref_mem[addr + 3] = wdata[31:24];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_mem_load"},    32'(mem_load),    32'd0);
    check({tag, "_mem_store"},   32'(mem_store),   32'd0);
    check({tag, "_mem_access"},  32'(mem_access),  32'd0);
    check({tag, "_mem_addr"},    mem_addr,         32'd0);
    check({tag, "_mem_wdata"},   mem_wdata,        32'd0);
    check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
    check({tag, "_resp_rdata"},  resp_rdata,       32'd0);
    check({tag, "_resp_rd"},     32'(resp_rd),     32'd0);
    check({tag, "_resp_fault"},  32'(resp_fault),  32'd0);
    check({tag, "_resp_cause"},  32'(resp_cause),  32'd0);
    check({tag, "_fault_count"}, 32'(fault_count), 32'd0);
  endtask

  task automatic hard_reset();
    rst        = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_faults = 0;
  endtask

  // Full request/response transaction checked against the reference model.
  task automatic xact(input logic ld, input logic st, input logic [2:0] acc,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input int hold);
    logic [1:0]  c;
    logic [31:0] erd;
    int          lat;
    int          nld;
    int          nst;
    logic        both;
    bit          got;
    c   = exp_cause(ld, st, acc, addr);
    lat = (c != 2'b00) ? 1 : (ld ? 3 : 2);
    erd = (c == 2'b00 && ld) ? exp_load(acc, addr) : 32'h0;
    if (c != 2'b00 && exp_faults < 16'hFFFF) exp_faults++;
    for (int w = 0; w < 10 && req_ready !== 1'b1; w++) @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_access = acc;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_load   = 1'($urandom);
    req_store  = 1'($urandom);
    req_access = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
    nld  = 0;
    nst  = 0;
    both = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) @(negedge clk);
      nld += int'(mem_load);
      nst += int'(mem_store);
      if (mem_load && mem_store) both = 1'b1;
      if (i == 1) begin
        check("mem_access_held", 32'(mem_access), 32'(acc));
        check("mem_addr_held", mem_addr, addr);
        check("mem_wdata_held", mem_wdata, wdata);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("fault_count_accept", 32'(fault_count), 32'(exp_faults));
      end
      if (i < lat) check("resp_valid_early", 32'(resp_valid), 32'd0);
    end
    check("resp_valid_latency", 32'(resp_valid), 32'd1);
    got = (resp_valid === 1'b1);
    for (int w = 0; w < 8 && !got; w++) begin
      @(negedge clk);
      nld += int'(mem_load);
      nst += int'(mem_store);
      got = (resp_valid === 1'b1);
    end
    check("mem_load_pulses", 32'(nld), (c == 2'b00 && ld) ? 32'd1 : 32'd0);
    check("mem_store_pulses", 32'(nst), (c == 2'b00 && st) ? 32'd1 : 32'd0);
    check("strobes_exclusive", 32'(both), 32'd0);
    if (!got) begin
      check("resp_timeout", 32'(resp_valid), 32'd1);
      hard_reset();
      return;
    end
    check("resp_rdata", resp_rdata, erd);
    check("resp_rd", 32'(resp_rd), 32'(rd));
    check("resp_fault", 32'(resp_fault), (c != 2'b00) ? 32'd1 : 32'd0);
    check("resp_cause", 32'(resp_cause), 32'(c));
    check("fault_count", 32'(fault_count), 32'(exp_faults));
    for (int h = 0; h < hold; h++) begin
      req_valid  = 1'b1;
      req_load   = 1'b1;
      req_store  = 1'b0;
      req_access = 3'b010;
      req_addr   = 32'h0000_0004;
      req_rd     = ~rd;
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_resp_rdata", resp_rdata, erd);
      check("hold_resp_rd", 32'(resp_rd), 32'(rd));
      check("hold_resp_cause", 32'(resp_cause), 32'(c));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_no_strobe", 32'(mem_load | mem_store), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_cleared", 32'(resp_valid), 32'd0);
    check("req_ready_after_resp", 32'(req_ready), 32'd1);
    check("no_strobe_after_resp", 32'(mem_load | mem_store), 32'd0);
    if (c == 2'b00 && st) ref_write(acc, addr, wdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld;
    logic        st;
    logic [2:0]  acc;
    logic [31:0] addr;
    int unsigned r;
    checks     = 0;
    errors     = 0;
    exp_faults = 0;
    for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = 8'h00;
    rst        = 1'b0;
    ram_clear  = 1'b1;
    req_valid  = 1'b0;
    req_load   = 1'b0;
    req_store  = 1'b0;
    req_access = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    req_rd     = '0;
    resp_ready = 1'b0;

    // Reset state and release.
    repeat (2) @(negedge clk);
    reset_outputs("reset");
    ram_clear = 1'b0;
    rst       = 1'b1;
    #1;
    check("req_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("req_ready_after_release", 32'(req_ready), 32'd1);

    // Word store then load of 0xDEADBEEF at 0x10, rd 5.
    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd0, 0);
    xact(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0);
    check("lw_deadbeef_model", exp_load(3'b010, 32'h10), 32'hDEAD_BEEF);

    // Store/load round trip at 0x20.
    xact(1'b0, 1'b1, 3'b010, 32'h20, 32'h1234_5678, 5'd3, 0);
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd7, 1);

    // Misaligned faults.
    xact(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 5'd1, 0);
    xact(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 5'd2, 0);
    check("two_misaligned_faults", 32'(fault_count), 32'd2);

    // Range and illegal faults.
    xact(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd9, 0);
    xact(1'b1, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd9, 0);
    xact(1'b0, 1'b1, 3'b100, 32'h30, 32'hAA, 5'd10, 0);
    xact(1'b1, 1'b1, 3'b010, 32'h30, 32'h0, 5'd11, 0);
    xact(1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 5'd12, 0);
    xact(1'b1, 1'b0, 3'b011, 32'h30, 32'h0, 5'd13, 0);
    xact(1'b1, 1'b0, 3'b010, 32'hFFC, 32'h0, 5'd14, 0);

    // Response stall with competing requests.
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd15, 5);

    // Byte and half accesses, pass-through of extension.
    xact(1'b0, 1'b1, 3'b000, 32'h31, 32'hFFFF_FF80, 5'd0, 0);
    xact(1'b1, 1'b0, 3'b000, 32'h31, 32'h0, 5'd16, 0);
    xact(1'b1, 1'b0, 3'b100, 32'h31, 32'h0, 5'd17, 0);
    xact(1'b0, 1'b1, 3'b001, 32'h32, 32'h0000_8001, 5'd0, 0);
    xact(1'b1, 1'b0, 3'b001, 32'h32, 32'h0, 5'd18, 2);
    xact(1'b1, 1'b0, 3'b101, 32'h32, 32'h0, 5'd19, 0);
    xact(1'b0, 1'b1, 3'b001, 32'h35, 32'h0, 5'd20, 0);
    check("lb_sign_model", exp_load(3'b000, 32'h31), 32'hFFFF_FF80);

    // Reset during the ISSUE cycle of a store.
    for (int w = 0; w < 10 && req_ready !== 1'b1; w++) @(negedge clk);
    check("pre_reset_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_load   = 1'b0;
    req_store  = 1'b1;
    req_access = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFE_F00D;
    req_rd     = 5'd21;
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_store_strobe", 32'(mem_store), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    reset_outputs("midreset");
    exp_faults = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("midreset_ready_after_edge", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midreset_no_resp", 32'(resp_valid), 32'd0);
      check("midreset_no_strobe", 32'(mem_load | mem_store), 32'd0);
    end
    xact(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd22, 0);

    // Random requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        ld = 1'($urandom);
        st = ld;
      end else begin
        ld = (r < 5);
        st = !ld;
      end
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0:       acc = 3'b000;
          1:       acc = 3'b001;
          2:       acc = 3'b010;
          3:       acc = 3'b100;
          default: acc = 3'b101;
        endcase
      end else begin
        acc = 3'($urandom);
      end
      addr = $urandom_range(0, MEM_SIZE - 1);
      if (acc[1:0] == 2'b01) addr[0] = 1'b0;
      if (acc[1:0] == 2'b10) addr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r == 0) addr = addr | 32'h1;
      else if (r == 1) addr = MEM_SIZE + $urandom_range(0, 64);
      xact(ld, st, acc, addr, $urandom, 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
